// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// DMEM_MISALIGN_TRAP_EN turns misaligned accesses into address errors.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit MISALIGN_TRAP = 1'b1;
`else
  localparam bit MISALIGN_TRAP = 1'b0;
`endif

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word RAM, registered read port.
// Read returns the pre-write value when written in the same cycle.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory slave with wait states.
// Build option: DMEM_MISALIGN_TRAP_EN flags Address[1:0] != 0 as error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Address,
  input  logic [WORD_W-1:0] WriteData,
  output logic [WORD_W-1:0] ReadData,
  output logic              Ready,
  output logic              AddrError
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  dmem_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic              op_rd;
  logic              op_wr;
  logic              bad_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rd_q;
  logic [WORD_W-1:0] rdata;
  logic              rd_src;
  logic              err_q;

  logic              req;
  logic              in_bad;
  logic              acc_now;
  logic              acc_rd;
  logic              acc_wr;
  logic              acc_bad;
  logic [AW-1:0]     acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic              we;

  assign req    = MemRead | MemWrite;
  assign in_bad = (|Address[31:AW+2])
                | (MISALIGN_TRAP & (|Address[1:0]));

  // With no wait states the access happens on the acceptance edge
  always_comb begin
    acc_now   = (state == DMEM_WAIT) && (cnt == '0);
    acc_rd    = op_rd;
    acc_wr    = op_wr;
    acc_bad   = bad_q;
    acc_addr  = idx_q;
    acc_wdata = wdata_q;
    if (ZERO_WAIT) begin
      acc_now   = (state == DMEM_IDLE) && req;
      acc_rd    = MemRead;
      acc_wr    = MemWrite;
      acc_bad   = in_bad;
      acc_addr  = Address[AW+1:2];
      acc_wdata = WriteData;
    end
  end

  assign we = acc_now & acc_wr & ~acc_bad;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clock(clock),
    .we   (we),
    .addr (acc_addr),
    .wdata(acc_wdata),
    .rdata(rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= DMEM_IDLE;
      cnt     <= '0;
      op_rd   <= 1'b0;
      op_wr   <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rd_src  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        DMEM_IDLE: begin
          if (req) begin
            op_rd   <= MemRead;
            op_wr   <= MemWrite;
            bad_q   <= in_bad;
            idx_q   <= Address[AW+1:2];
            wdata_q <= WriteData;
            if (ZERO_WAIT) begin
              state <= DMEM_RESP;
            end else begin
              state <= DMEM_WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        DMEM_WAIT: begin
          if (cnt == '0) state <= DMEM_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        DMEM_RESP: begin
          state  <= DMEM_IDLE;
          err_q  <= 1'b0;
          rd_src <= 1'b0;
          if (rd_src) rd_q <= rdata;
        end
        default: state <= DMEM_IDLE;
      endcase
      // RAM read data is valid in RESP; it is folded into rd_q on exit
      if (acc_now) begin
        err_q  <= acc_bad;
        rd_src <= acc_rd & ~acc_bad;
        if (acc_bad) rd_q <= '0;
      end
    end
  end

  assign Ready     = (state == DMEM_RESP);
  assign AddrError = err_q;
  assign ReadData  = (Ready && rd_src) ? rdata : rd_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed + random checks against a word-array model.
// Honours DMEM_MISALIGN_TRAP_EN when it is defined for the build.
module tb_dmem_responder;

  localparam int W = 2;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TB_TRAP = 1'b1;
`else
  localparam bit TB_TRAP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        d_rd = 0, d_wr = 0;
  logic [31:0] d_a = 0, d_d = 0, d_q;
  logic        d_rdy, d_err;

  logic        z_rd = 0, z_wr = 0;
  logic [31:0] z_a = 0, z_d = 0, z_q;
  logic        z_rdy, z_err;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) u_dut (
    .clock(clock), .reset(reset),
    .MemRead(d_rd), .MemWrite(d_wr),
    .Address(d_a), .WriteData(d_d),
    .ReadData(d_q), .Ready(d_rdy), .AddrError(d_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_zw (
    .clock(clock), .reset(reset),
    .MemRead(z_rd), .MemWrite(z_wr),
    .Address(z_a), .WriteData(z_d),
    .ReadData(z_q), .Ready(z_rdy), .AddrError(z_err)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [256];
  logic [31:0] exp_rd = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full request on the wait-state DUT, checked cycle by cycle
  task automatic req(input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] d);
    bit bad;
    int unsigned w;
    logic exp_err;
    bad = ((a >> 2) >= 32'd256) || (TB_TRAP && (a % 4 != 0));
    w = (a >> 2) % 256;
    if (bad) begin
      exp_err = 1'b1;
      exp_rd  = 32'h0;
    end else begin
      exp_err = 1'b0;
      if (rd) exp_rd = mem_m[w];
      if (wr) mem_m[w] = d;
    end
    d_rd = rd; d_wr = wr; d_a = a; d_d = d;
    for (int k = 1; k <= W + 1; k++) begin
      @(posedge clock); #1;
      if (k <= W) begin
        chk("ready_in_wait", {31'b0, d_rdy}, 32'd0);
      end else begin
        chk("ready_pulse", {31'b0, d_rdy}, 32'd1);
        chk("addr_error", {31'b0, d_err}, {31'b0, exp_err});
        chk("read_data", d_q, exp_rd);
      end
    end
    d_rd = 0; d_wr = 0;
    @(posedge clock); #1;
    chk("ready_drop", {31'b0, d_rdy}, 32'd0);
    chk("err_drop", {31'b0, d_err}, 32'd0);
    chk("data_hold", d_q, exp_rd);
  endtask

  initial begin
    logic [31:0] a;
    int unsigned sel, op;

    #1;
    chk("rst_ready", {31'b0, d_rdy}, 32'd0);
    chk("rst_err", {31'b0, d_err}, 32'd0);
    chk("rst_data", d_q, 32'h0);
    chk("rst_z_data", z_q, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) req(0, 1, 32'(i * 4), $urandom);

    req(0, 1, 32'h10, 32'hDEADBEEF);
    req(1, 0, 32'h10, 32'h0);

    req(0, 1, 32'h400, 32'h0BAD0BAD);
    req(1, 0, 32'h400, 32'h0);
    req(1, 0, 32'h0, 32'h0);

    req(0, 1, 32'h10, 32'h11111111);
    req(1, 1, 32'h10, 32'h22222222);
    req(1, 0, 32'h10, 32'h0);

    req(0, 1, 32'h12, 32'h5555AAAA);
    req(1, 0, 32'h10, 32'h0);

    // Reset during WAIT drops the pending write to word 8
    d_wr = 1; d_a = 32'h20; d_d = 32'hA5A5A5A5;
    @(posedge clock); #1;
    chk("rst_wait_ready", {31'b0, d_rdy}, 32'd0);
    d_wr = 0;
    reset = 1'b0;
    #1;
    chk("rst_async_ready", {31'b0, d_rdy}, 32'd0);
    chk("rst_async_data", d_q, 32'h0);
    chk("rst_async_err", {31'b0, d_err}, 32'd0);
    exp_rd = 32'h0;
    repeat (2) begin
      @(posedge clock); #1;
      chk("rst_no_ready", {31'b0, d_rdy}, 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    req(1, 0, 32'h20, 32'h0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15)) * 4;
      if (sel == 0) a = a + 32'h400 * 32'($urandom_range(1, 8));
      if (sel == 1) a = a | 32'($urandom_range(1, 3));
      op = $urandom_range(1, 3);
      req(op[0], op[1], a, $urandom);
    end

    // Zero-wait instance: write, then a held read pulses every 2 cycles
    z_wr = 1; z_a = 32'h8; z_d = 32'hCAFEF00D;
    @(posedge clock); #1;
    chk("zw_write_ready", {31'b0, z_rdy}, 32'd1);
    chk("zw_write_err", {31'b0, z_err}, 32'd0);
    z_wr = 0; z_rd = 1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clock); #1;
      chk("zw_ready", {31'b0, z_rdy}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) chk("zw_data", z_q, 32'hCAFEF00D);
    end
    z_rd = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the MIPS datapath: the memory-side end of the processor's `MemRead`/`MemWrite`/`Address`/`WriteData`/`ReadData` data-memory interface. It latches one word request, inserts a configurable number of wait states and then answers with a one-cycle `Ready` pulse. This lets the core be moved from an ideal combinational `d_mem` to a realistic stalled memory. It sits between the core's load/store path and a word-addressed RAM array.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words stored; power of two, ≥ 4.
- `WAIT_CYCLES`, default 2: wait states between acceptance and response; 0 to 15 allowed.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low; the name follows the codebase.
- `MemRead` in 1: read request; held by the core until `Ready`.
- `MemWrite` in 1: write request; held by the core until `Ready`.
- `Address` in 32: byte address; word index = `Address[31:2]`.
- `WriteData` in 32: write data; sampled only at acceptance.
- `ReadData` out 32: read result; valid while `Ready`=1, then held.
- `Ready` out 1: one-cycle completion pulse.
- `AddrError` out 1: qualifies `Ready`; high when the request was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:** if `MemRead|MemWrite`=1 on a rising edge, latch op, word index, `WriteData` and `Address[1:0]`.
  - Go to WAIT with counter = `WAIT_CYCLES`-1.
  - If `WAIT_CYCLES`=0, go directly to RESP.
- **WAIT:** decrement the counter. At counter 0, the edge leaving WAIT performs the access and enters RESP.
  - Request inputs are ignored during WAIT; only latched values are used.
- **Access:**
  - Write: `mem[idx]` <= latched data. `ReadData` is unchanged.
  - Read: `ReadData` <= `mem[idx]`.
- **Both requests set:** the write is performed. `ReadData` returns the word's pre-write contents.
- **Out of range** (`idx` ≥ `DEPTH_WORDS`):
  - No write occurs.
  - `ReadData` <= 32'h0000_0000.
  - `AddrError`=1 during RESP.
- **RESP:** `Ready`=1 for exactly one cycle, then return to IDLE unconditionally. Request inputs are ignored in RESP.
- **Back-to-back requests:** a request present in the IDLE cycle after RESP is accepted. The minimum request spacing is `WAIT_CYCLES`+2 cycles.
- **Memory contents:** not reset; undefined until written.

## Timing
- Request first visible in cycle 0 and accepted at the end of cycle 0.
- WAIT occupies cycles 1..`WAIT_CYCLES`.
- `Ready` is high in cycle `WAIT_CYCLES`+1.
- `ReadData` and `AddrError` are registered, valid in the same cycle as `Ready`.
- After `Ready`, `ReadData` holds its last value and `AddrError` returns to 0.
- Reset values: `Ready`=0, `AddrError`=0, `ReadData`=32'h0, state=IDLE, counter=0.
- **Reset asserted mid-operation:**
  - Outputs and FSM return to reset values immediately, asynchronously.
  - A pending write is dropped; a write already committed stays.
- **After reset deassertion:** the first acceptance can happen on the first rising edge with `reset`=1.

## Configuration
- Macro: `DMEM_MISALIGN_TRAP_EN`.
- **Defined:** a latched `Address[1:0]` ≠ 2'b00 is treated exactly like out-of-range:
  - no write;
  - `ReadData`=0;
  - `AddrError`=1 with `Ready`.
- **Undefined:** `Address[1:0]` is ignored. Accesses go to the aligned word, and `AddrError` only flags out-of-range.

## Structure
- Shared package `dmem_pkg`:
  - state enum typedef (`DMEM_IDLE`, `DMEM_WAIT`, `DMEM_RESP`);
  - `WORD_W`=32 constant;
  - wait-counter width constant (4).
- Sub-module `dmem_array`: single-port synchronous RAM.
  - Ports: `clock`, `we`, `addr`, `wdata`, `rdata`.
  - Read data is registered and gives the pre-write value on simultaneous write.
  - The FSM, counter and error logic stay in `dmem_responder`.

## Test plan
- **Write/read:** `WAIT_CYCLES`=2; write 32'hDEADBEEF to 0x10, then read 0x10 → `Ready` in cycle 3 of each request, `ReadData`=32'hDEADBEEF, `AddrError`=0.
- **Zero wait:** `WAIT_CYCLES`=0; read request in cycle 0 → `Ready` in cycle 1. Back-to-back reads give one `Ready` every 2 cycles.
- **Out of range:** `DEPTH_WORDS`=256; write to 0x400, then read 0x400 → `AddrError`=1, `ReadData`=0; word 0 is unchanged.
- **Simultaneous read/write:** mem[4]=32'h11111111; `MemRead`=`MemWrite`=1 at 0x10 with data 32'h22222222 → `ReadData`=32'h11111111. A following read returns 32'h22222222.
- **Reset mid-WAIT:** drop `reset` during a write to 0x20 while in WAIT → `Ready` never pulses and mem[8] keeps its old value. The next request after release completes normally.
- **Misaligned access:** write to 0x12.
  - With `DMEM_MISALIGN_TRAP_EN`: `AddrError`=1 and mem[4] is unchanged.
  - Without it: mem[4] is written and `AddrError`=0.
